// File: rtl/md_sequencer_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Includes the execute-stage opcode decode that selects mult/div.
package md_sequencer_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_ALU     = 5'b00000;
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StRun,
    StFixup,
    StDone
  } md_state_e;

  // Returns {is_mult, is_div} for an opcode/aluop pair.
  function automatic logic [1:0] md_decode(input logic [4:0] op, input logic [4:0] aluop);
    md_decode = {(op == OP_ALU) && (aluop == ALUOP_MULT),
                 (op == OP_ALU) && (aluop == ALUOP_DIV)};
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Start/operand/result bundle between the execute stage and the sequencer.
interface md_sequencer_if
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic             ctrl_mult;
  logic             ctrl_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             result_rdy;
  logic             busy;

  modport master (
    output ctrl_mult, ctrl_div, operand_a, operand_b,
    input  result, exception, result_rdy, busy
  );

  modport slave (
    input  ctrl_mult, ctrl_div, operand_a, operand_b,
    output result, exception, result_rdy, busy
  );

endinterface

// File: rtl/md_addsub.sv
// Adder/subtractor shared by the multiply and divide datapaths.
// Subtraction is a + ~b + 1.
module md_addsub #(
  parameter int unsigned WIDTH = 33
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign sum_o = a_i + b_eff + {{(WIDTH-1){1'b0}}, sub_i};

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) sequencer.
// hi_q/lo_q hold the double-width product, or remainder/quotient during divide.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input logic           clock,
  input logic           reset_n,
  md_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic [WIDTH:0]   add_a, add_b, add_sum;
  logic             add_sub;
  logic             start_ok;

  md_addsub #(
    .WIDTH(WIDTH + 1)
  ) u_addsub (
    .a_i  (add_a),
    .b_i  (add_b),
    .sub_i(add_sub),
    .sum_o(add_sum)
  );

  assign start_ok = bus.ctrl_mult ^ bus.ctrl_div;

  // Operand steering into the single add/sub unit.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == StRun) begin
      add_b = {1'b0, b_q};
      if (op_div_q) begin
        add_a   = {hi_q, lo_q[WIDTH-1]};
        add_sub = 1'b1;
      end else begin
        add_a = {1'b0, hi_q};
      end
    end else if (state_q == StFixup) begin
      // 0 - lo_q: conditional negate of the magnitude result
      add_b   = {1'b0, lo_q};
      add_sub = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    exc_d    = exc_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d  = StPrep;
          op_div_d = bus.ctrl_div;
          lo_d     = bus.operand_a;
          b_d      = bus.operand_b;
          result_d = '0;
          exc_d    = 1'b0;
        end
      end

      StPrep: begin
        sign_d = lo_q[WIDTH-1] ^ b_q[WIDTH-1];
        lo_d   = lo_q[WIDTH-1] ? -lo_q : lo_q;
        b_d    = b_q[WIDTH-1] ? -b_q : b_q;
        hi_d   = '0;
        cnt_d  = '0;
        if (op_div_q && (b_q == '0)) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (op_div_q) begin
          // Negative trial difference means restore the shifted remainder.
          hi_d = add_sum[WIDTH] ? add_a[WIDTH-1:0] : add_sum[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
        end else if (lo_q[0]) begin
          {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFixup;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StFixup: begin
        result_d = sign_q ? add_sum[WIDTH-1:0] : lo_q;
        if (op_div_q) begin
          // Only MinNeg / -1 yields a positive quotient of 2^(WIDTH-1).
          exc_d = ~sign_q & lo_q[WIDTH-1];
        end else begin
          exc_d = (hi_q != '0) || (lo_q[WIDTH-1] && !(sign_q && (lo_q == MinNeg)));
        end
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign bus.result     = result_q;
  assign bus.exception  = exc_q;
  assign bus.result_rdy = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized and directed checks of md_sequencer against an arithmetic reference model.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer #(
    .WIDTH(32)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference computed with 64-bit signed arithmetic, independent of the datapath.
  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e);
    longint sa, sb, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_div && b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      v = is_div ? (sa / sb) : (sa * sb);
      r = v[31:0];
      e = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    end
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input int glitch, input string tag);
    logic [31:0] er;
    bit          ee;
    logic [1:0]  dec;
    int          exp_lat;
    int          n;
    bit          busy_ok;
    model(is_div, a, b, er, ee);
    exp_lat = (is_div && b == 32'd0) ? 2 : 35;
    dec = md_decode(OP_ALU, is_div ? ALUOP_DIV : ALUOP_MULT);
    bus.ctrl_mult = dec[1];
    bus.ctrl_div  = dec[0];
    bus.operand_a = a;
    bus.operand_b = b;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!bus.busy) busy_ok = 1'b0;
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = (n == glitch);
      if (n == glitch) begin
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
      end
    end while (!bus.result_rdy && n < 100);
    bus.ctrl_div = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, 64'(bus.result), 64'(er));
    check({tag, "_exception"}, 64'(bus.exception), 64'(ee));
    check({tag, "_busy_during"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'({bus.busy, bus.result_rdy}), 64'd0);
    check({tag, "_result_hold"}, 64'({bus.result, bus.exception}), 64'({er, ee}));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'($signed($urandom_range(0, 40)) - 20);
      1:       v = 32'd0;
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      4:       v = 32'($urandom_range(0, 65535));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int  idle_bad;
    int  rdy_seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.result, bus.exception, bus.result_rdy, bus.busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd6, 32'd7, 0, "mul_6x7");
    run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 0, "mul_neg3x5");
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, "mul_ovf");
    run_op(1'b0, 32'h8000_0000, 32'd1, 0, "mul_minx1");
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "mul_minxm1");
    run_op(1'b1, 32'd100, 32'd7, 0, "div_100_7");
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, "div_m100_7");
    run_op(1'b1, 32'd5, 32'd0, 0, "div_by_zero");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    run_op(1'b1, 32'h8000_0000, 32'd1, 0, "div_min_1");
    run_op(1'b0, 32'd1234, 32'd5678, 12, "mul_div_glitch");

    // Both start flags at once must be ignored.
    bus.ctrl_mult = 1'b1;
    bus.ctrl_div  = 1'b1;
    bus.operand_a = 32'd9;
    bus.operand_b = 32'd9;
    @(negedge clk);
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy || bus.result_rdy) idle_bad++;
      @(negedge clk);
    end
    check("both_start_ignored", 64'(idle_bad), 64'd0);

    // Reset in the middle of a multiply.
    bus.ctrl_mult = 1'b1;
    bus.operand_a = 32'd77;
    bus.operand_b = 32'd88;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.ctrl_mult = 1'b0;
    end
    check("midrun_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({bus.result, bus.exception, bus.result_rdy, bus.busy}),
          64'd0);
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.result_rdy || bus.busy) rdy_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.result_rdy || bus.busy) rdy_seen++;
    end
    check("midrun_no_rdy", 64'(rdy_seen), 64'd0);
    run_op(1'b0, 32'd2, 32'd3, 0, "mul_after_reset");

    for (int i = 0; i < 40; i++) begin
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      d = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      run_op(d, a, b, (i % 5 == 0) ? 7 : 0, d ? "rnd_div" : "rnd_mul");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle signed multiply/divide unit for the processor execute stage.
- Runs when the opcode decode flags a mult or div instruction (OP=00000 with ALUOP=00110 or 00111).
- Sequences one shared add/subtract resource through WIDTH shift-add (mult) or restoring trial-subtract (div) iterations.
- Drives busy to stall the pipeline and pulses result_rdy when the writeback value is valid.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
clock  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
ctrl_mult  input  1  start pulse for multiply, sampled only in IDLE
ctrl_div  input  1  start pulse for divide, sampled only in IDLE
operand_a  input  WIDTH  multiplicand / dividend, signed two's complement, sampled with start
operand_b  input  WIDTH  multiplier / divisor, signed two's complement, sampled with start
result  output  WIDTH  product low word or quotient
exception  output  1  overflow or divide-by-zero, valid while result_rdy=1
result_rdy  output  1  one-cycle pulse, result/exception valid
busy  output  1  high from the cycle after start until the cycle result_rdy is high (inclusive); pipeline stall

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, result=0, exception=0, result_rdy=0, busy=0, all internal regs 0. Reset asserted mid-operation aborts immediately; no result_rdy follows.
- States:
  - IDLE: waits for a start pulse.
  - PREP: take absolute values; record result sign = sign_a XOR sign_b; divide-by-zero check.
  - RUN: WIDTH iterations.
  - FIXUP: conditional negate; overflow check.
  - DONE: result_rdy=1 for one cycle, then return to IDLE.
- Start rules:
  - Exactly one of ctrl_mult/ctrl_div high in IDLE: latch operands and op, go to PREP.
  - Both high at once: ignored, stay IDLE.
  - Either high outside IDLE: ignored.
- Latency: start sampled at edge 0 → PREP during cycle 1 → RUN cycles 2..WIDTH+1 → FIXUP cycle WIDTH+2 → result_rdy high during cycle WIDTH+3 (35 for WIDTH=32). Back-to-back: a new start is accepted in the IDLE cycle that follows DONE.
- Multiply: 2*WIDTH-bit unsigned shift-add on the magnitudes; the add/sub unit is used with sub=0.
  - result = low WIDTH bits of the signed product.
  - exception=1 if the signed 2*WIDTH product does not fit in WIDTH signed bits.
- Divide: restoring division, one quotient bit per iteration; the add/sub unit is used with sub=1 for the trial subtract, and the remainder is restored when the difference is negative.
  - Quotient truncates toward zero.
  - Divide-by-zero: PREP goes directly to DONE; result=0, exception=1, result_rdy in cycle 2.
  - Most-negative / -1: result=0x80000000 (WIDTH=32), exception=1.
- result and exception hold their values after DONE until the next start is accepted; at that point they clear to 0.
- Counter: log2(WIDTH)+1 bits, loaded 0 in PREP, increments in RUN, exits RUN when it reaches WIDTH-1; it never wraps.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, PREP, RUN, FIXUP, DONE);
  - opcode constants OP_ALU=5'b00000, ALUOP_MULT=5'b00110, ALUOP_DIV=5'b00111;
  - WIDTH default.
- One sub-module is natural: md_addsub, a WIDTH+1-bit adder/subtractor with a sub select (b inverted plus carry-in). The sequencer instantiates it once and shares it between the mult and div paths.

Test Plan:
- Multiply 6 × 7: pulse ctrl_mult with a=6, b=7 → busy for 35 cycles, result_rdy at cycle 35, result=42, exception=0.
- Signed multiply -3 × 5: a=0xFFFFFFFD, b=5 → result=0xFFFFFFF1 (-15), exception=0. Overflow multiply a=0x00010000, b=0x00010000 → result=0x00000000, exception=1.
- Divide 100 / 7 → result=14; -100 / 7 → result=0xFFFFFFF2 (-14); both with exception=0 and latency 35.
- Divide by zero: a=5, b=0 → result_rdy at cycle 2, result=0, exception=1, busy deasserts after that cycle.
- Start filtering: ctrl_mult and ctrl_div high together in IDLE → no busy, no result_rdy. ctrl_div pulsed mid-multiply → ignored, and the multiply result is unchanged.
- Reset mid-run: reset_n low at cycle 10 of a multiply → all outputs 0 immediately, no result_rdy. A new 2 × 3 issued after release → result=6.
